// File: rtl/axi_mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding, latched request record
// and the default out-of-range read pattern.
package mem_resp_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic [31:0] OOR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } mem_resp_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  oor;
  } mem_req_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// Simple synchronous memory bus between the AXI-lite bridge (master) and the responder (slave).
interface axi_mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_oor;

  modport master (
    output mem_req, mem_addr, mem_wr, mem_wdata,
    input  mem_ack, mem_rdata, mem_oor
  );

  modport slave (
    input  mem_req, mem_addr, mem_wr, mem_wdata,
    output mem_ack, mem_rdata, mem_oor
  );
endinterface

// File: rtl/axi_mem_responder_sram.sv
// Single-port synchronous SRAM, DEPTH x DATA_W, registered read port, contents not reset.
module mem_resp_sram #(
  parameter  int unsigned DEPTH  = 256,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_mem_responder.sv
// Memory responder behind the AXI-lite bridge: wait-stated SRAM access with out-of-range flagging.
// Optional read/write completion counters under `define MEM_STATS_EN.
module axi_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       WAIT_CYC  = 2,
  parameter logic [DATA_W-1:0] OOR_RDATA = DATA_W'(OOR_RDATA_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_mem_responder_if.slave   bus,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_wr_cnt
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  mem_resp_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              mem_ack_q, mem_ack_d;
  logic              mem_oor_q, mem_oor_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              access;
  logic              sram_we, sram_re;
  logic [IDX_W-1:0]  sram_idx;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic              in_oor;
  logic              unused_addr_bits;

  assign in_oor = |(bus.mem_addr >> (IDX_W + 2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          req_d.addr  = MEM_ADDR_W'(bus.mem_addr);
          req_d.wr    = bus.mem_wr;
          req_d.wdata = MEM_DATA_W'(bus.mem_wdata);
          req_d.oor   = in_oor;
          cnt_d       = CNT_W'(WAIT_CYC);
          if (WAIT_CYC == 0) begin
            access  = 1'b1;
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          access  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (!bus.mem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_d is the request being serviced in both the zero-wait IDLE path and the WAIT path
  assign sram_we    = access &&  req_d.wr && !req_d.oor;
  assign sram_re    = access && !req_d.wr && !req_d.oor;
  assign sram_idx   = req_d.addr[IDX_W+1:2];
  assign sram_wdata = DATA_W'(req_d.wdata);
  assign unused_addr_bits = ^{req_d.addr[MEM_ADDR_W-1:IDX_W+2], req_d.addr[1:0]};

  always_comb begin
    mem_ack_d   = (state_q == ACK);
    mem_oor_d   = (state_q == ACK) && req_q.oor;
    mem_rdata_d = mem_rdata_q;
    if (state_q == ACK && !req_q.wr) begin
      mem_rdata_d = req_q.oor ? OOR_RDATA : sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      mem_ack_q   <= 1'b0;
      mem_oor_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      mem_ack_q   <= mem_ack_d;
      mem_oor_q   <= mem_oor_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  mem_resp_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .idx   (sram_idx),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_oor   = mem_oor_q;
  assign bus.mem_rdata = mem_rdata_q;

`ifdef MEM_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;

  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (state_q == ACK) begin
      if (req_q.wr) begin
        if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
      end else begin
        if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (DEPTH=256, WAIT_CYC=2).
module tb_axi_mem_responder;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;
  int          n_cmp  = 0;
  int          n_fail = 0;

  axi_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus();

  axi_mem_responder #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (256),
    .WAIT_CYC  (2),
    .OOR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );

  always #5 clk = ~clk;

  // Drives one request, returns edges from capture to ack (-1 on timeout), then releases mem_req.
  task automatic bus_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic oor, output int lat);
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_addr = addr; bus.mem_wr = wr; bus.mem_wdata = wdata;
    @(posedge clk);
    lat = -1; rd = '0; oor = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        lat = i; rd = bus.mem_rdata; oor = bus.mem_oor;
        break;
      end
    end
    bus.mem_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_wr = 1'b0; bus.mem_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.mem_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.mem_ack); end
    n_cmp++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
    n_cmp++; if (bus.mem_oor !== 1'b0) begin n_fail++; $display("FAIL reset_oor: got %b want 0", bus.mem_oor); end
    n_cmp++; if (stat_rd_cnt !== 16'h0 || stat_wr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_stats: got rd=%0d wr=%0d want 0/0", stat_rd_cnt, stat_wr_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic oor; int lat;
    bus_access(32'h10, 1'b1, 32'hA5A5_0001, rd, oor, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (oor !== 1'b0) begin n_fail++; $display("FAIL wr_oor: got %b want 0", oor); end
    bus_access(32'h0, 1'b1, 32'h0BAD_F00D, rd, oor, lat);
    bus_access(32'h10, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_data: got %h want a5a50001", rd); end
    n_cmp++; if (oor !== 1'b0) begin n_fail++; $display("FAIL rd_oor: got %b want 0", oor); end
    bus_access(32'h13, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_lowbits: got %h want a5a50001", rd); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic oor; int lat;
    bus_access(32'h3FC, 1'b1, 32'hCAFE_0FFF, rd, oor, lat);
    bus_access(32'h3FC, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'hCAFE_0FFF || oor !== 1'b0) begin
      n_fail++; $display("FAIL top_word: got %h oor=%b want cafe0fff oor=0", rd, oor);
    end
    bus_access(32'h400, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'hDEAD_BEEF || oor !== 1'b1) begin
      n_fail++; $display("FAIL oor_read: got %h oor=%b want deadbeef oor=1", rd, oor);
    end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL oor_latency: got %0d want 3", lat); end
    bus_access(32'h400, 1'b1, 32'h0000_1234, rd, oor, lat);
    n_cmp++; if (oor !== 1'b1) begin n_fail++; $display("FAIL oor_write_flag: got %b want 1", oor); end
    bus_access(32'h0, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'h0BAD_F00D || oor !== 1'b0) begin
      n_fail++; $display("FAIL oor_write_dropped: got %h oor=%b want 0badf00d oor=0", rd, oor);
    end
    bus_access(32'h8000_0000, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'hDEAD_BEEF || oor !== 1'b1) begin
      n_fail++; $display("FAIL oor_msb: got %h oor=%b want deadbeef oor=1", rd, oor);
    end
  endtask

  task automatic test_hold_req();
    logic [31:0] rd; logic oor; int lat;
    int acks = 0;
    int ack_at = -1;
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h10; bus.mem_wr = 1'b0; bus.mem_wdata = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        acks++;
        if (ack_at < 0) ack_at = i;
      end
    end
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL hold_single_ack: got %0d acks want 1", acks); end
    n_cmp++; if (ack_at !== 4) begin n_fail++; $display("FAIL hold_ack_cycle: got %0d want 4", ack_at); end
    n_cmp++; if (bus.mem_rdata !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL hold_rdata_held: got %h want a5a50001", bus.mem_rdata);
    end
    bus.mem_req = 1'b0;
    repeat (2) @(posedge clk);
    bus_access(32'h0, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (lat !== 3 || rd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL hold_next_req: got lat=%0d data=%h want lat=3 data=0badf00d", lat, rd);
    end
  endtask

  task automatic test_latched();
    logic [31:0] rd; logic oor; int lat;
    int acks = 0;
    bus_access(32'h24, 1'b1, 32'h4444_5555, rd, oor, lat);
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h20; bus.mem_wr = 1'b1; bus.mem_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus.mem_req = 1'b0; bus.mem_addr = 32'h24; bus.mem_wr = 1'b0; bus.mem_wdata = 32'h3333_3333;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) acks++;
    end
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL latched_ack: got %0d acks want 1", acks); end
    n_cmp++; if (bus.mem_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL write_keeps_rdata: got %h want 0badf00d", bus.mem_rdata);
    end
    bus_access(32'h20, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL latched_wdata: got %h want 11112222", rd); end
    bus_access(32'h24, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'h4444_5555) begin n_fail++; $display("FAIL latched_addr: got %h want 44445555", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic oor; int lat;
    int acks = 0;
    bus_access(32'h30, 1'b1, 32'h6666_6666, rd, oor, lat);
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h30; bus.mem_wr = 1'b1; bus.mem_wdata = 32'h7777_7777;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL ack_in_reset: got %0d acks want 0", acks); end
    n_cmp++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_in_reset: got %h want 0", bus.mem_rdata); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL stale_ack: got %0d acks want 0", acks); end
    bus_access(32'h30, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (lat !== 3 || rd !== 32'h6666_6666) begin
      n_fail++; $display("FAIL post_reset_read: got lat=%0d data=%h want lat=3 data=66666666", lat, rd);
    end
    bus_access(32'h40, 1'b1, 32'h0000_0040, rd, oor, lat);
    bus_access(32'h44, 1'b1, 32'h0000_0044, rd, oor, lat);
    bus_access(32'h800, 1'b1, 32'h0000_0800, rd, oor, lat);
    bus_access(32'h44, 1'b0, 32'h0, rd, oor, lat);
    n_cmp++; if (rd !== 32'h0000_0044) begin n_fail++; $display("FAIL post_reset_data: got %h want 00000044", rd); end
`ifdef MEM_STATS_EN
    n_cmp++; if (stat_wr_cnt !== 16'd3 || stat_rd_cnt !== 16'd2) begin
      n_fail++; $display("FAIL stats: got wr=%0d rd=%0d want wr=3 rd=2", stat_wr_cnt, stat_rd_cnt);
    end
`else
    n_cmp++; if (stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stats_tied: got wr=%0d rd=%0d want 0/0", stat_wr_cnt, stat_rd_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundary();
    test_hold_req();
    test_latched();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Memory-side responder directly downstream of the AXI-lite slave bridge.
- Consumes the bridge's simple synchronous memory interface (mem_req/mem_addr/mem_wr/mem_wdata) and returns mem_ack/mem_rdata.
- Backed by a local word-addressed SRAM with parameterised wait states.
- Flags out-of-range accesses.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; word = DATA_W/8 bytes.
- DEPTH, 256, number of SRAM words; power of two, >= 2.
- WAIT_CYC, 2, wait states between request capture and access; 0..15.
- OOR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- mem_req  in  1  request; held high by the bridge until it samples mem_ack.
- mem_addr  in  ADDR_W  byte address.
- mem_wr  in  1  1 = write, 0 = read.
- mem_wdata  in  DATA_W  write data.
- mem_ack  out  1  single-cycle completion pulse.
- mem_rdata  out  DATA_W  read data; valid in the mem_ack cycle, then held.
- mem_oor  out  1  pulses with mem_ack when the access was out of range.
- stat_rd_cnt  out  16  completed read count (MEM_STATS_EN only).
- stat_wr_cnt  out  16  completed write count (MEM_STATS_EN only).

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: mem_ack=0, mem_rdata=0, mem_oor=0, state=IDLE, wait counter=0, latched request=0, stats=0.
  - SRAM contents are not reset.
- Address decode:
  - word index = mem_addr[log2(DEPTH)+1:2]; mem_addr[1:0] ignored.
  - Out of range when any mem_addr bit above log2(DEPTH)+1 is set.
- FSM states: IDLE, WAIT, ACK, RELEASE.
  - IDLE: on mem_req=1, latch addr/wr/wdata/oor and load cnt=WAIT_CYC.
    - If WAIT_CYC=0, perform the access at this edge and go to ACK.
    - Otherwise go to WAIT.
  - WAIT: decrement cnt each cycle. At the edge where cnt==1, perform the access and go to ACK.
  - ACK: mem_ack=1 for exactly one cycle, go to RELEASE.
  - RELEASE: go to IDLE when mem_req=0; stay while mem_req=1.
    - This guarantees the still-high mem_req in the cycle after ACK is never re-accepted as a new request.
- Access rules:
  - In-range write: SRAM[idx] <= wdata.
  - In-range read: mem_rdata <= SRAM[idx].
  - Out-of-range write: dropped.
  - Out-of-range read: mem_rdata <= OOR_RDATA.
  - Either out-of-range case: mem_oor=1 together with mem_ack.
  - Writes do not change mem_rdata.
- Latency: ack is asserted in the cycle starting WAIT_CYC+1 edges after the edge that captured mem_req.
  - Minimum req-to-req spacing is one idle cycle after ACK.
- Latched semantics:
  - mem_addr/mem_wr/mem_wdata changes after capture are ignored.
  - If mem_req drops during WAIT, the latched access still completes and mem_ack still pulses (no abort).
- Reset mid-operation: the FSM returns to IDLE immediately and the pending access is discarded.
  - If the access edge was already passed, the SRAM write stands.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined:
  - stat_rd_cnt/stat_wr_cnt increment on each ACK cycle by access type, including out-of-range accesses.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counters are synthesised.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum mem_resp_state_e (IDLE, WAIT, ACK, RELEASE);
  - localparam OOR_RDATA_DEFAULT;
  - struct mem_req_t {addr, wr, wdata, oor} for the latched request.
- Sub-module mem_resp_sram:
  - single-port synchronous array, DEPTH x DATA_W;
  - inputs we/re/idx/wdata, registered rdata, no reset on contents.

Test Plan:
- WAIT_CYC=2, write addr 0x10 data 0xA5A5_0001, then read 0x10:
  - ack exactly 3 edges after each capture;
  - rdata=0xA5A5_0001 in the read ack cycle;
  - mem_oor=0.
- mem_req held high for 5 cycles after ack:
  - only one ack pulse;
  - FSM stays in RELEASE until mem_req falls, then the next request is accepted.
- DEPTH=256, read 0x400:
  - rdata=0xDEAD_BEEF with mem_oor=1.
- DEPTH=256, write 0x400 data 0x1234 then read 0x000:
  - the earlier word at 0x000 is unchanged (write dropped);
  - mem_oor=1 on the write ack.
- Change mem_addr/mem_wdata and drop mem_req during WAIT:
  - access uses the captured values;
  - ack still pulses once.
- Assert rst_n low during WAIT, then release and issue a read:
  - mem_ack=0 during reset;
  - no stale ack afterwards;
  - with MEM_STATS_EN, counts after 3 writes + 2 reads read stat_wr_cnt=3, stat_rd_cnt=2.
